audio_sample_scheduler: RTL and testbench

Sample-rate scheduler for the audioport clk domain. Decodes one-hot command words from the APB register block and runs the PLAY/IDLE state. While playing, it divides clk down to the 48 kHz sample tick. On each tick it pops one stereo sample from the left/right audio FIFOs, hands it to dsp_unit with a req/ack handshake, and raises the underrun interrupt and status flags.

---
 rtl/audioport_pkg.sv | 49 ++++
 rtl/sample_tick_gen.sv | 34 +++
 rtl/audio_sample_scheduler.sv | 147 ++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audioport_pkg.sv
// Shared audioport definitions: command codes, status
// bit indices, scheduler state and command decode.
package audioport_pkg;

    localparam logic [31:0] CMD_NOP    = 32'h0000_0000;
    localparam logic [31:0] CMD_CLR    = 32'h0000_0001;
    localparam logic [31:0] CMD_CFG    = 32'h0000_0002;
    localparam logic [31:0] CMD_START  = 32'h0000_0004;
    localparam logic [31:0] CMD_STOP   = 32'h0000_0008;
    localparam logic [31:0] CMD_LEVEL  = 32'h0000_0010;
    localparam logic [31:0] CMD_IRQACK = 32'h0000_0020;

    localparam int STATUS_PLAY   = 0;
    localparam int STATUS_NODATA = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_POP,
        S_DSP_BUSY
    } sched_state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_CLR,
        C_CFG,
        C_START,
        C_STOP,
        C_LEVEL,
        C_IRQACK
    } sched_cmd_t;

    // Exact-match decode: NOP, multi-bit and unknown words map to C_NONE
    function automatic sched_cmd_t decode_cmd(input logic [31:0] w);
        sched_cmd_t c;
        c = C_NONE;
        case (w)
            CMD_CLR:    c = C_CLR;
            CMD_CFG:    c = C_CFG;
            CMD_START:  c = C_START;
            CMD_STOP:   c = C_STOP;
            CMD_LEVEL:  c = C_LEVEL;
            CMD_IRQACK: c = C_IRQACK;
            default:    c = C_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider: one-cycle registered tick every
// DIV enabled cycles, first tick DIV cycles after enable.
module sample_tick_gen #(
    parameter int DIV = 2084
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_clr || !i_en) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/audio_sample_scheduler.sv
// Audioport sample scheduler: command decode, PLAY/IDLE
// control, FIFO pop and dsp_unit req/ack per sample tick.
module audio_sample_scheduler
    import audioport_pkg::*;
#(
    parameter int CLK_DIV     = 2084,
    parameter int DSP_TIMEOUT = 131
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_in,
    input  logic [31:0] cmd_in,
    input  logic        fifo_empty_in,
    output logic        fifo_pop_out,
    output logic        dsp_req_out,
    input  logic        dsp_ack_in,
    output logic        clr_out,
    output logic        cfg_out,
    output logic        level_out,
    output logic        tick_out,
    output logic        play_out,
    output logic        nodata_out,
    output logic        irq_out,
    output logic        dsp_err_out
);

    localparam int TO_W = $clog2(DSP_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DSP_TIMEOUT - 1);

    sched_state_t    r_state;
    logic [TO_W-1:0] r_to;
    logic [1:0]      r_status;
    logic            r_pop;
    logic            r_req;
    logic            r_clr;
    logic            r_cfg;
    logic            r_level;
    logic            r_irq;
    logic            r_err;

    sched_cmd_t      w_cmd;
    logic            w_stop;
    logic            w_tick;

    assign w_cmd  = cmd_valid_in ? decode_cmd(cmd_in) : C_NONE;
    assign w_stop = (w_cmd == C_STOP) && (r_state != S_IDLE);

    sample_tick_gen #(
        .DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_status[STATUS_PLAY]),
        .i_clr  (w_stop),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_to     <= '0;
            r_status <= '0;
            r_pop    <= 1'b0;
            r_req    <= 1'b0;
            r_clr    <= 1'b0;
            r_cfg    <= 1'b0;
            r_level  <= 1'b0;
            r_irq    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_clr   <= 1'b0;
            r_cfg   <= 1'b0;
            r_level <= 1'b0;
            r_pop   <= 1'b0;
            // A set later in this block overrides the ack clear
            if (w_cmd == C_IRQACK)
                r_irq <= 1'b0;
            if (r_state == S_IDLE) begin
                case (w_cmd)
                    C_CLR: begin
                        r_clr                   <= 1'b1;
                        r_status[STATUS_NODATA] <= 1'b0;
                        r_err                   <= 1'b0;
                    end
                    C_CFG:   r_cfg   <= 1'b1;
                    C_LEVEL: r_level <= 1'b1;
                    C_START: begin
                        r_state                 <= S_WAIT_TICK;
                        r_status[STATUS_PLAY]   <= 1'b1;
                        r_status[STATUS_NODATA] <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (w_stop) begin
                r_state               <= S_IDLE;
                r_status[STATUS_PLAY] <= 1'b0;
                r_req                 <= 1'b0;
            end else begin
                unique case (r_state)
                    S_WAIT_TICK: begin
                        if (w_tick) begin
                            if (!fifo_empty_in) begin
                                r_state <= S_POP;
                                r_pop   <= 1'b1;
                            end else begin
                                r_status[STATUS_NODATA] <= 1'b1;
                                r_irq                   <= 1'b1;
                            end
                        end
                    end
                    S_POP: begin
                        r_state <= S_DSP_BUSY;
                        r_req   <= 1'b1;
                        r_to    <= '0;
                    end
                    S_DSP_BUSY: begin
                        if (w_tick)
                            r_err <= 1'b1;
                        if (dsp_ack_in) begin
                            r_req   <= 1'b0;
                            r_state <= S_WAIT_TICK;
                        end else if (r_to == TO_LAST) begin
                            r_err   <= 1'b1;
                            r_req   <= 1'b0;
                            r_state <= S_WAIT_TICK;
                        end else begin
                            r_to <= r_to + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign fifo_pop_out = r_pop;
    assign dsp_req_out  = r_req;
    assign clr_out      = r_clr;
    assign cfg_out      = r_cfg;
    assign level_out    = r_level;
    assign tick_out     = w_tick;
    assign play_out     = r_status[STATUS_PLAY];
    assign nodata_out   = r_status[STATUS_NODATA];
    assign irq_out      = r_irq;
    assign dsp_err_out  = r_err;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench for audio_sample_scheduler: a CLK_DIV=2084
// instance for most scenarios and a CLK_DIV=8 one for overrun.
module tb_audio_sample_scheduler;
    import audioport_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd = '0;
    logic        fifo_empty = 1'b0;
    logic        ack = 1'b0;
    logic        pop, req, clr, cfg, level, tick;
    logic        play, nodata, irq, err;

    logic        cmd_valid8 = 1'b0;
    logic [31:0] cmd8 = '0;
    logic        fifo_empty8 = 1'b0;
    logic        ack8 = 1'b0;
    logic        pop8, req8, clr8, cfg8, level8, tick8;
    logic        play8, nodata8, irq8, err8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_sample_scheduler #(
        .CLK_DIV     (2084),
        .DSP_TIMEOUT (131)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_in  (cmd_valid),
        .cmd_in        (cmd),
        .fifo_empty_in (fifo_empty),
        .fifo_pop_out  (pop),
        .dsp_req_out   (req),
        .dsp_ack_in    (ack),
        .clr_out       (clr),
        .cfg_out       (cfg),
        .level_out     (level),
        .tick_out      (tick),
        .play_out      (play),
        .nodata_out    (nodata),
        .irq_out       (irq),
        .dsp_err_out   (err)
    );

    audio_sample_scheduler #(
        .CLK_DIV     (8),
        .DSP_TIMEOUT (131)
    ) dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid_in  (cmd_valid8),
        .cmd_in        (cmd8),
        .fifo_empty_in (fifo_empty8),
        .fifo_pop_out  (pop8),
        .dsp_req_out   (req8),
        .dsp_ack_in    (ack8),
        .clr_out       (clr8),
        .cfg_out       (cfg8),
        .level_out     (level8),
        .tick_out      (tick8),
        .play_out      (play8),
        .nodata_out    (nodata8),
        .irq_out       (irq8),
        .dsp_err_out   (err8)
    );

    task automatic send_cmd(input logic [31:0] w);
        cmd_valid = 1'b1;
        cmd = w;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = '0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        while (tick !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [9:0] v;
        rst_n = 1'b0;
        #1;
        v = {play, nodata, irq, err, req, pop, tick, clr, cfg, level};
        checks++;
        if (v !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_play;
        int n;
        int h;
        fifo_empty = 1'b0;
        send_cmd(CMD_START);
        checks++;
        if (play !== 1'b1) begin
            errors++;
            $display("FAIL start_play got %b want 1", play);
        end
        wait_tick(n);
        checks++;
        if (n != 2084) begin
            errors++;
            $display("FAIL first_tick got %0d want 2084", n);
        end
        checks++;
        if (pop !== 1'b0) begin
            errors++;
            $display("FAIL pop_at_tick got %b want 0", pop);
        end
        @(negedge clk);
        checks++;
        if (pop !== 1'b1) begin
            errors++;
            $display("FAIL pop_t1 got %b want 1", pop);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || pop !== 1'b0) begin
            errors++;
            $display("FAIL req_t2 got req=%b pop=%b want 1/0", req, pop);
        end
        h = 0;
        while (req === 1'b1 && h < 200) begin
            if (h == 2) ack = 1'b1;
            @(negedge clk);
            h++;
        end
        ack = 1'b0;
        checks++;
        if (h != 3) begin
            errors++;
            $display("FAIL req_width got %0d want 3", h);
        end
        wait_tick(n);
        checks++;
        if (n != 2079) begin
            errors++;
            $display("FAIL tick_period got %0d want 2079", n);
        end
        @(negedge clk);
        checks++;
        if (pop !== 1'b1) begin
            errors++;
            $display("FAIL pop_second got %b want 1", pop);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL req_second got req=%b err=%b want 1/0", req, err);
        end
    endtask

    task automatic test_timeout;
        int h;
        h = 0;
        while (req === 1'b1 && h < 400) begin
            @(negedge clk);
            h++;
        end
        checks++;
        if (h != 131) begin
            errors++;
            $display("FAIL timeout_cycles got %0d want 131", h);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_err got %b want 1", err);
        end
    endtask

    task automatic test_stop_tick;
        int n;
        wait_tick(n);
        checks++;
        if (n != 2084 - 133) begin
            errors++;
            $display("FAIL tick_after_to got %0d want 1951", n);
        end
        cmd_valid = 1'b1;
        cmd = CMD_STOP;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd = '0;
        checks++;
        if (pop !== 1'b0 || play !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_tick got pop=%b play=%b tick=%b want 0/0/0",
                     pop, play, tick);
        end
        @(negedge clk);
        checks++;
        if (req !== 1'b0 || irq !== 1'b0 || pop !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle got req=%b irq=%b pop=%b want 0/0/0",
                     req, irq, pop);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] words [3];
        logic [3:0]  v;
        words[0] = 32'h3;
        words[1] = 32'h40;
        words[2] = CMD_NOP;
        for (int i = 0; i < 3; i++) begin
            send_cmd(words[i]);
            v = {play, clr, cfg, level};
            checks++;
            if (v !== 4'b0) begin
                errors++;
                $display("FAIL illegal_%0h got %b want 0", words[i], v);
            end
        end
    endtask

    task automatic test_idle_cmds;
        send_cmd(CMD_CFG);
        checks++;
        if (cfg !== 1'b1 || clr !== 1'b0 || level !== 1'b0) begin
            errors++;
            $display("FAIL cfg_pulse got %b%b%b want 010", clr, cfg, level);
        end
        @(negedge clk);
        checks++;
        if (cfg !== 1'b0) begin
            errors++;
            $display("FAIL cfg_width got %b want 0", cfg);
        end
        send_cmd(CMD_LEVEL);
        checks++;
        if (level !== 1'b1 || cfg !== 1'b0) begin
            errors++;
            $display("FAIL level_pulse got %b want 1", level);
        end
        @(negedge clk);
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL level_width got %b want 0", level);
        end
        send_cmd(CMD_CLR);
        checks++;
        if (clr !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL clr_pulse got clr=%b err=%b want 1/0", clr, err);
        end
        @(negedge clk);
        checks++;
        if (clr !== 1'b0) begin
            errors++;
            $display("FAIL clr_width got %b want 0", clr);
        end
    endtask

    task automatic test_underrun;
        int n;
        fifo_empty = 1'b1;
        send_cmd(CMD_START);
        wait_tick(n);
        checks++;
        if (n != 2084) begin
            errors++;
            $display("FAIL underrun_tick got %0d want 2084", n);
        end
        @(negedge clk);
        checks++;
        if (nodata !== 1'b1 || irq !== 1'b1 || pop !== 1'b0) begin
            errors++;
            $display("FAIL underrun got nodata=%b irq=%b pop=%b want 1/1/0",
                     nodata, irq, pop);
        end
        send_cmd(CMD_CFG);
        send_cmd(CMD_CLR);
        send_cmd(CMD_LEVEL);
        send_cmd(CMD_START);
        checks++;
        if ({cfg, clr, level} !== 3'b0 || nodata !== 1'b1) begin
            errors++;
            $display("FAIL play_cmds got %b%b%b nodata=%b want 000/1",
                     cfg, clr, level, nodata);
        end
        send_cmd(CMD_IRQACK);
        checks++;
        if (irq !== 1'b0 || nodata !== 1'b1) begin
            errors++;
            $display("FAIL irqack got irq=%b nodata=%b want 0/1", irq, nodata);
        end
        send_cmd(CMD_STOP);
        checks++;
        if (play !== 1'b0) begin
            errors++;
            $display("FAIL underrun_stop got %b want 0", play);
        end
        send_cmd(CMD_CLR);
        checks++;
        if (clr !== 1'b1 || nodata !== 1'b0) begin
            errors++;
            $display("FAIL clr_nodata got clr=%b nodata=%b want 1/0",
                     clr, nodata);
        end
        fifo_empty = 1'b0;
    endtask

    task automatic test_reset_busy;
        int n;
        logic [9:0] v;
        send_cmd(CMD_START);
        wait_tick(n);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL busy_req got %b want 1", req);
        end
        #2 rst_n = 1'b0;
        #1;
        v = {play, nodata, irq, err, req, pop, tick, clr, cfg, level};
        checks++;
        if (v !== 10'b0) begin
            errors++;
            $display("FAIL async_reset got %b want 0", v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (play !== 1'b0 || req !== 1'b0 || pop !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got play=%b req=%b pop=%b want 0/0/0",
                     play, req, pop);
        end
    endtask

    task automatic test_overrun_div8;
        int n;
        fifo_empty8 = 1'b0;
        cmd_valid8 = 1'b1;
        cmd8 = CMD_START;
        @(negedge clk);
        cmd_valid8 = 1'b0;
        cmd8 = '0;
        n = 0;
        while (tick8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL div8_tick got %0d want 8", n);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (tick8 !== 1'b1 || err8 !== 1'b0 || req8 !== 1'b1) begin
            errors++;
            $display("FAIL div8_pre got tick=%b err=%b req=%b want 1/0/1",
                     tick8, err8, req8);
        end
        @(negedge clk);
        checks++;
        if (err8 !== 1'b1 || req8 !== 1'b1) begin
            errors++;
            $display("FAIL div8_overrun got err=%b req=%b want 1/1",
                     err8, req8);
        end
        cmd_valid8 = 1'b1;
        cmd8 = CMD_STOP;
        @(negedge clk);
        cmd_valid8 = 1'b0;
        cmd8 = '0;
        checks++;
        if (req8 !== 1'b0 || play8 !== 1'b0) begin
            errors++;
            $display("FAIL div8_stop got req=%b play=%b want 0/0", req8, play8);
        end
    endtask

    initial begin
        test_reset();
        test_play();
        test_timeout();
        test_stop_tick();
        test_illegal();
        test_idle_cmds();
        test_underrun();
        test_reset_busy();
        test_overrun_div8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
